// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback request payload type.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rw;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry writeback holding register with valid flag and read-address match outputs.
module wb_hold_slot #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] in_rw,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic              valid,
    output logic [ADDR_W-1:0] rw,
    output logic [DATA_W-1:0] data,
    output logic              match_a_c,
    output logic              match_b_c
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] rw_q, rw_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Load wins over clear so a drain and a refill can share one edge.
    always_comb begin
        valid_d = valid_q;
        rw_d    = rw_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            rw_d    = in_rw;
            data_d  = in_data;
        end else if (clear) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            rw_q    <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rw_q    <= rw_d;
            data_q  <= data_d;
        end
    end

    assign valid     = valid_q;
    assign rw        = rw_q;
    assign data      = data_q;
    assign match_a_c = valid_q && (rw_q == ra);
    assign match_b_c = valid_q && (rw_q == rb);

endmodule

// File: rtl/wb_write_arbiter.sv
// Two-port writeback arbiter for the register file write port with RAW hazard flags.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin on different-register conflicts; default is load-port priority.
module wb_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_arstn,
    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic [ADDR_W-1:0] i_req0_rw,
    input  logic [DATA_W-1:0] i_req0_data,
    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic [ADDR_W-1:0] i_req1_rw,
    input  logic [DATA_W-1:0] i_req1_data,
    output logic [ADDR_W-1:0] o_RW,
    output logic [DATA_W-1:0] o_BUS_W,
    output logic              o_WE,
    input  logic [ADDR_W-1:0] i_RA,
    input  logic [ADDR_W-1:0] i_RB,
    output logic              o_hazard_A,
    output logic              o_hazard_B,
    output logic              o_drop_r0
);

    localparam logic [ADDR_W-1:0] ZERO_RW = ADDR_W'(REG_ZERO);

    logic              h0_valid, h1_valid;
    logic [ADDR_W-1:0] h0_rw, h1_rw;
    logic [DATA_W-1:0] h0_data, h1_data;
    logic              h0_match_a, h0_match_b, h1_match_a, h1_match_b;

    logic grant0_c, grant1_c, conflict_c;
    logic acc0_c, acc1_c, load0_c, load1_c;
    logic h0_next_c, h1_next_c;

    logic              age_q, age_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] rw_q, rw_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              drop_q, drop_d;
`ifdef WB_ARB_ROUND_ROBIN_EN
    logic              rr_q, rr_d;
`endif

    wb_hold_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_hold0 (
        .clk       (i_clk),
        .rst_n     (i_arstn),
        .load      (load0_c),
        .clear     (grant0_c),
        .in_rw     (i_req0_rw),
        .in_data   (i_req0_data),
        .ra        (i_RA),
        .rb        (i_RB),
        .valid     (h0_valid),
        .rw        (h0_rw),
        .data      (h0_data),
        .match_a_c (h0_match_a),
        .match_b_c (h0_match_b)
    );

    wb_hold_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_hold1 (
        .clk       (i_clk),
        .rst_n     (i_arstn),
        .load      (load1_c),
        .clear     (grant1_c),
        .in_rw     (i_req1_rw),
        .in_data   (i_req1_data),
        .ra        (i_RA),
        .rb        (i_RB),
        .valid     (h1_valid),
        .rw        (h1_rw),
        .data      (h1_data),
        .match_a_c (h1_match_a),
        .match_b_c (h1_match_b)
    );

    // Grant selection; age_q high means hold1 was loaded before hold0.
    always_comb begin
        grant0_c   = 1'b0;
        grant1_c   = 1'b0;
        conflict_c = 1'b0;
        if (h0_valid && h1_valid) begin
            if (h0_rw == h1_rw) begin
                grant1_c = age_q;
                grant0_c = !age_q;
            end else begin
                conflict_c = 1'b1;
`ifdef WB_ARB_ROUND_ROBIN_EN
                grant1_c   = rr_q;
`else
                grant1_c   = 1'b1;
`endif
                grant0_c   = !grant1_c;
            end
        end else begin
            grant0_c = h0_valid;
            grant1_c = h1_valid;
        end
    end

    assign o_req0_ready = !h0_valid || grant0_c;
    assign o_req1_ready = !h1_valid || grant1_c;

    assign acc0_c  = i_req0_valid && o_req0_ready;
    assign acc1_c  = i_req1_valid && o_req1_ready;
    assign load0_c = acc0_c && (i_req0_rw != ZERO_RW);
    assign load1_c = acc1_c && (i_req1_rw != ZERO_RW);

    assign h0_next_c = load0_c || (h0_valid && !grant0_c);
    assign h1_next_c = load1_c || (h1_valid && !grant1_c);

    // Next state for age, output registers and r0 drop pulse.
    always_comb begin
        age_d  = age_q;
        we_d   = 1'b0;
        rw_d   = rw_q;
        data_d = data_q;
        drop_d = (acc0_c && (i_req0_rw == ZERO_RW)) || (acc1_c && (i_req1_rw == ZERO_RW));

        if (load0_c && load1_c) begin
            age_d = 1'b0;
        end else if (load0_c && h1_next_c) begin
            age_d = 1'b1;
        end else if (load1_c && h0_next_c) begin
            age_d = 1'b0;
        end

        if (grant0_c) begin
            we_d   = 1'b1;
            rw_d   = h0_rw;
            data_d = h0_data;
        end else if (grant1_c) begin
            we_d   = 1'b1;
            rw_d   = h1_rw;
            data_d = h1_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            age_q  <= 1'b0;
            we_q   <= 1'b0;
            rw_q   <= '0;
            data_q <= '0;
            drop_q <= 1'b0;
        end else begin
            age_q  <= age_d;
            we_q   <= we_d;
            rw_q   <= rw_d;
            data_q <= data_d;
            drop_q <= drop_d;
        end
    end

`ifdef WB_ARB_ROUND_ROBIN_EN
    // Pointer flips only when a different-register conflict was resolved.
    always_comb begin
        rr_d = rr_q;
        if (conflict_c) begin
            rr_d = !rr_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    assign o_WE      = we_q;
    assign o_RW      = rw_q;
    assign o_BUS_W   = data_q;
    assign o_drop_r0 = drop_q;

    assign o_hazard_A = (i_RA != ZERO_RW) &&
                        (h0_match_a || h1_match_a || (we_q && (rw_q == i_RA)));
    assign o_hazard_B = (i_RB != ZERO_RW) &&
                        (h0_match_b || h1_match_b || (we_q && (rw_q == i_RB)));

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Shares the register file's single write port between two writeback requesters: port 0 for ALU results and port 1 for memory-load results. Each requester has a one-entry holding register with a valid/ready handshake. Each cycle the block picks one pending write and drives the register file's write address, data and enable from registered outputs. It also flags read-after-write hazards for the two read addresses while a write is still pending or in flight.

## Interface
Parameters:
- `DATA_W`, 32, width of write data.
- `ADDR_W`, 5, width of register address.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_arstn`  in  1  asynchronous, active-low reset.
- `i_req0_valid`  in  1  port 0 (ALU) write request.
- `o_req0_ready`  out  1  port 0 can accept this cycle.
- `i_req0_rw`  in  ADDR_W  port 0 destination register.
- `i_req0_data`  in  DATA_W  port 0 write data.
- `i_req1_valid`, `o_req1_ready`, `i_req1_rw`, `i_req1_data`: the same signals for port 1 (load).
- `o_RW`  out  ADDR_W  register file write address (registered).
- `o_BUS_W`  out  DATA_W  register file write data (registered).
- `o_WE`  out  1  register file write enable (registered).
- `i_RA`, `i_RB`  in  ADDR_W  register addresses being read this cycle.
- `o_hazard_A`, `o_hazard_B`  out  1  combinational; high when a pending or in-flight write targets `i_RA` / `i_RB`.
- `o_drop_r0`  out  1  one-cycle pulse when an accepted write to r0 is discarded (registered).

## Operation
- Handshake:
  - Transfer on port n occurs when `valid & ready` is high at the clock edge.
  - `o_reqN_ready = !holdN_valid | grantN`, so a drain and a refill can happen in the same cycle.
  - Request data is captured into `holdN`.
  - Requesters must hold `valid` and `rw`/`data` stable until the transfer completes.
- r0 handling:
  - A request with `rw == 0` is accepted normally but never enters the hold.
  - Instead it pulses `o_drop_r0` on the following cycle and never asserts `o_WE`.
- Arbitration:
  - Considers only valid holds.
  - If exactly one hold is valid, that hold is granted.
  - If both are valid and target the same register, the older entry is granted; an age flag records which hold was loaded first.
  - If both are loaded in the same cycle to the same register, port 0 counts as older, so port 1's value is the final one.
  - If both are valid and target different registers, the policy is set by Configuration.
- Grant effect:
  - The granted hold clears at the edge.
  - `o_RW`/`o_BUS_W` load from it and `o_WE` becomes 1.
  - With no grant, `o_WE` becomes 0 and `o_RW`/`o_BUS_W` hold their previous values.
- Hazard:
  - `o_hazard_A` is high when `i_RA != 0` and `i_RA` matches any valid hold's rw, or matches `o_RW` while `o_WE` is high.
  - `o_hazard_B` is the same using `i_RB`.
  - Address 0 never produces a hazard.
- Reset (asynchronous, any time):
  - Both holds are invalid and the age flag is cleared.
  - The round-robin pointer is set to port 0.
  - `o_RW = 0`, `o_BUS_W = 0`, `o_WE = 0`, `o_drop_r0 = 0`.
  - Requests pending at reset are lost.
- Internal state per port: hold valid, rw, data. Shared: one age bit and one round-robin pointer bit. There is no other FSM.

## Timing
- Latency:
  - A request accepted at edge E is visible in the hold after E.
  - If it is granted at edge E+1, `o_WE` is high between E+1 and E+2.
  - The register file commits it at edge E+2. Best case is therefore 2 edges from acceptance to commit.
- Throughput: 1 write per cycle total. A port that loses arbitration stalls for exactly the cycles it is not granted.
- Ready timing: `o_reqN_ready` depends combinationally on grant, not on `i_reqN_valid`. There is no combinational path from valid to ready.
- Hazard timing: `o_hazard_*` are valid in the same cycle as `i_RA`/`i_RB`. They remain high through the `o_WE` cycle, because the register file's read data is registered.

## Configuration
- `WB_ARB_ROUND_ROBIN_EN` defined:
  - Different-register conflicts are resolved round-robin.
  - The pointer names the preferred port and toggles to the other port after every conflicted grant.
  - Non-conflicted grants leave the pointer unchanged.
- Undefined:
  - Fixed priority; port 1 (load) always wins.
  - The pointer register is not implemented.
- Same-register ordering by age applies in both builds.

## Structure
- Shared package `regfile_pkg`:
  - `REG_ADDR_W = 5`, `REG_DATA_W = 32`, `REG_ZERO = 5'd0`.
  - Typedef `wb_req_t` with fields `rw` and `data`.
- One sub-module, `wb_hold_slot`, instantiated twice: one-entry holding register with valid flag, load/clear, and address-match output for hazard comparison.
- Grant logic, age bit, pointer and output registers live in the top.

## Test plan
- Reset mid-traffic: assert `i_arstn=0` with both holds full.
  - Required: `o_WE=0`, both ready high, `o_hazard_*=0` immediately.
  - Required: no write after release.
- Single write: port 0 writes rw=5, data=0xDEADBEEF.
  - Required: `o_WE=1`, `o_RW=5`, `o_BUS_W=0xDEADBEEF` exactly two edges after acceptance.
  - Required: `o_hazard_A=1` for `i_RA=5` during those two cycles.
- r0 write: port 1 writes rw=0.
  - Required: `o_drop_r0` pulses once, `o_WE` stays 0, no hazard for `i_RA=0`.
- Same-register race: both ports write rw=7 in the same cycle (port 0: 0x1, port 1: 0x2).
  - Required: port 0 is committed first, then port 1, so the final value is 0x2.
- Different-register contention, both ports valid for 4 cycles:
  - With `WB_ARB_ROUND_ROBIN_EN`: grants alternate 0,1,0,1.
  - Without it: port 1 wins all cycles while port 0 stays stalled (`o_req0_ready=0`).
- Back-to-back streaming: port 0 valid every cycle, port 1 idle.
  - Required: one write per cycle, `o_req0_ready` continuously high.
